fp_add_arbiter: RTL

Round-robin scheduler that shares one pipelined `fp_adder` instance among `N_REQ` independent requesters. It accepts at most one operand pair per cycle over a valid/ready handshake and drives the adder's `A`/`B` inputs from a registered operand stage. It tracks each in-flight operation with a requester tag through a shift pipe matched to the adder latency, then returns each result on a shared response bus tagged with the originating requester. It sits between the client blocks and the `fp_adder` core.

---
 rtl/fp_add_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin front end sharing one pipelined fp_adder
// among N_REQ requesters, with tagged, in-order result return.
module fp_add_arbiter #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int N_REQ = 4,
  parameter int LAT = 4,
  localparam int W = E_WIDTH + M_WIDTH + 1,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0] req_ready,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_res,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic             busy
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_vld;

  logic [W-1:0] add_a_q, add_a_d;
  logic [W-1:0] add_b_q, add_b_d;

  // Entry 0 travels with the operand register; entry LAT lines up
  // with the adder result that the response register samples.
  logic [LAT:0]    tag_vld_q, tag_vld_d;
  logic [ID_W-1:0] tag_id_q [LAT+1];
  logic [ID_W-1:0] tag_id_d [LAT+1];

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;

  // Rotating-priority search; iterate far-to-near so the nearest wins.
  always_comb begin : arb_c
    int idx;
    idx = 0;
    gnt_vld = 1'b0;
    gnt_id = '0;
    req_ready = '0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      idx = (int'(ptr_q) + o) % N_REQ;
      if (en && !rst && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  // Pointer advance, operand capture and tag/response pipe inputs.
  always_comb begin
    ptr_d = ptr_q;
    add_a_d = '0;
    add_b_d = '0;
    if (gnt_vld) begin
      ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      add_a_d = req_a[int'(gnt_id)*W +: W];
      add_b_d = req_b[int'(gnt_id)*W +: W];
    end
    tag_vld_d = {tag_vld_q[LAT-1:0], gnt_vld};
    tag_id_d[0] = gnt_id;
    for (int j = 1; j <= LAT; j++) tag_id_d[j] = tag_id_q[j-1];
    rsp_valid_d = tag_vld_q[LAT];
    rsp_id_d = tag_vld_q[LAT] ? tag_id_q[LAT] : rsp_id_q;
    rsp_data_d = tag_vld_q[LAT] ? add_res : rsp_data_q;
  end

  // State registers; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      tag_vld_q <= '0;
      for (int j = 0; j <= LAT; j++) tag_id_q[j] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      tag_vld_q <= tag_vld_d;
      for (int j = 0; j <= LAT; j++) tag_id_q[j] <= tag_id_d[j];
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign busy = (|tag_vld_q) | rsp_valid_q;

endmodule
